daq_packet_parser: RTL

//  Receive-side counterpart of the DAQ packet stream: consumes the byte stream from the DAQ transmit

---
 rtl/daq_packet_parser.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/daq_packet_parser.sv
// Receive-side parser for the DAQ byte stream: hunts for SYNC, captures the 8-byte header,
// assembles ch0/ch1 sample pairs into a one-entry output register and tracks framing errors.
module daq_packet_parser #(
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [7:0]       i_s_tdata,
   input  logic             i_s_tvalid,
   output logic             o_s_tready,
   input  logic             i_s_tlast,
   output logic [31:0]      o_hdr_timestamp,
   output logic [7:0]       o_hdr_capture_len,
   output logic [15:0]      o_hdr_error_flags,
   output logic             o_hdr_valid,
   output logic [15:0]      o_m_ch0,
   output logic [15:0]      o_m_ch1,
   output logic             o_m_valid,
   input  logic             i_m_ready,
   output logic             o_m_last,
   output logic             o_pkt_done,
   output logic             o_err_sync,
   output logic             o_err_len,
   output logic [CNT_W-1:0] o_pkt_count,
   output logic [CNT_W-1:0] o_err_count
);

   typedef enum logic [1:0] {StHunt, StHdr, StData, StDrain} state_e;

   state_e             r_state;
   state_e             w_state_d;
   logic [2:0]         r_byte_idx;
   logic [31:0]        r_ts_sh;
   logic [7:0]         r_len_sh;
   logic [7:0]         r_flags_hi_sh;
   logic [1:0]         r_frame_idx;
   logic [15:0]        r_ch0_sh;
   logic [7:0]         r_ch1_hi_sh;
   logic [8:0]         r_smp_cnt;
   logic               r_rdy_en;

   logic [31:0]        r_hdr_ts;
   logic [7:0]         r_hdr_len;
   logic [15:0]        r_hdr_flags;
   logic               r_hdr_valid;
   logic [15:0]        r_m_ch0;
   logic [15:0]        r_m_ch1;
   logic               r_m_valid;
   logic               r_m_last;
   logic               r_pkt_done;
   logic               r_err_sync;
   logic               r_err_len;
   logic [CNT_W-1:0]   r_pkt_count;
   logic [CNT_W-1:0]   r_err_count;

   logic               w_frame_stall;
   logic               w_accept;
   logic               w_is_sync;
   logic               w_last_pair;
   logic               w_pkt_done_d;
   logic               w_err_len_d;
   logic               w_err_sync_d;
   logic               w_hdr_load;
   logic               w_pair_load;
   logic               w_enter_data;

   // Only the completing byte of a frame must wait for the output register to free up.
   assign w_frame_stall = (r_state == StData) && (r_frame_idx == 2'd3) && r_m_valid && !i_m_ready;
   assign o_s_tready    = r_rdy_en && !w_frame_stall;
   assign w_accept      = i_s_tvalid && o_s_tready;
   assign w_is_sync     = (i_s_tdata == SYNC_BYTE);
   assign w_last_pair   = ((r_smp_cnt + 9'd1) == {1'b0, r_len_sh});

   always_comb begin
      w_state_d    = r_state;
      w_pkt_done_d = 1'b0;
      w_err_len_d  = 1'b0;
      w_err_sync_d = 1'b0;
      w_hdr_load   = 1'b0;
      w_pair_load  = 1'b0;
      w_enter_data = 1'b0;
      case (r_state)
         StHunt: begin
            if (w_accept) begin
               if (!w_is_sync) begin
                  w_err_sync_d = 1'b1;
               end else if (i_s_tlast) begin
                  w_err_len_d = 1'b1;
               end else begin
                  w_state_d = StHdr;
               end
            end
         end
         StHdr: begin
            if (w_accept) begin
               if (r_byte_idx == 3'd7) begin
                  w_hdr_load = 1'b1;
                  if (r_len_sh == 8'd0) begin
                     if (i_s_tlast) begin
                        w_pkt_done_d = 1'b1;
                        w_state_d    = StHunt;
                     end else begin
                        w_err_len_d = 1'b1;
                        w_state_d   = StDrain;
                     end
                  end else if (i_s_tlast) begin
                     w_err_len_d = 1'b1;
                     w_state_d   = StHunt;
                  end else begin
                     w_enter_data = 1'b1;
                     w_state_d    = StData;
                  end
               end else if (i_s_tlast) begin
                  w_err_len_d = 1'b1;
                  w_state_d   = StHunt;
               end
            end
         end
         StData: begin
            if (w_accept) begin
               if (r_frame_idx == 2'd3) begin
                  w_pair_load = 1'b1;
                  if (w_last_pair) begin
                     if (i_s_tlast) begin
                        w_pkt_done_d = 1'b1;
                        w_state_d    = StHunt;
                     end else begin
                        w_err_len_d = 1'b1;
                        w_state_d   = StDrain;
                     end
                  end else if (i_s_tlast) begin
                     w_err_len_d = 1'b1;
                     w_state_d   = StHunt;
                  end
               end else if (i_s_tlast) begin
                  w_err_len_d = 1'b1;
                  w_state_d   = StHunt;
               end
            end
         end
         StDrain: begin
            if (w_accept && i_s_tlast) begin
               w_state_d = StHunt;
            end
         end
         default: w_state_d = StHunt;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StHunt;
         r_rdy_en <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_rdy_en <= 1'b1;
      end
   end

   // Header shadow registers: byte 1..4 timestamp, 5 capture_len, 6 flags MSB; byte 7 goes direct.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_byte_idx    <= 3'd0;
         r_ts_sh       <= 32'd0;
         r_len_sh      <= 8'd0;
         r_flags_hi_sh <= 8'd0;
      end else if (w_accept) begin
         if (r_state == StHunt) begin
            r_byte_idx <= 3'd1;
         end else if (r_state == StHdr) begin
            r_byte_idx <= r_byte_idx + 3'd1;
            case (r_byte_idx)
               3'd1, 3'd2, 3'd3, 3'd4: r_ts_sh <= {r_ts_sh[23:0], i_s_tdata};
               3'd5:                   r_len_sh <= i_s_tdata;
               3'd6:                   r_flags_hi_sh <= i_s_tdata;
               default:                ;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_frame_idx <= 2'd0;
         r_smp_cnt   <= 9'd0;
         r_ch0_sh    <= 16'd0;
         r_ch1_hi_sh <= 8'd0;
      end else if (w_enter_data) begin
         r_frame_idx <= 2'd0;
         r_smp_cnt   <= 9'd0;
      end else if (w_accept && (r_state == StData)) begin
         r_frame_idx <= r_frame_idx + 2'd1;
         case (r_frame_idx)
            2'd0:    r_ch0_sh[15:8] <= i_s_tdata;
            2'd1:    r_ch0_sh[7:0]  <= i_s_tdata;
            2'd2:    r_ch1_hi_sh    <= i_s_tdata;
            default: r_smp_cnt      <= r_smp_cnt + 9'd1;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hdr_ts    <= 32'd0;
         r_hdr_len   <= 8'd0;
         r_hdr_flags <= 16'd0;
         r_hdr_valid <= 1'b0;
      end else begin
         r_hdr_valid <= w_hdr_load;
         if (w_hdr_load) begin
            r_hdr_ts    <= r_ts_sh;
            r_hdr_len   <= r_len_sh;
            r_hdr_flags <= {r_flags_hi_sh, i_s_tdata};
         end
      end
   end

   // One-entry output register; a load in the same cycle as a sink accept keeps m_valid high.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_m_ch0   <= 16'd0;
         r_m_ch1   <= 16'd0;
         r_m_valid <= 1'b0;
         r_m_last  <= 1'b0;
      end else if (w_pair_load) begin
         r_m_ch0   <= r_ch0_sh;
         r_m_ch1   <= {r_ch1_hi_sh, i_s_tdata};
         r_m_valid <= 1'b1;
         r_m_last  <= w_last_pair;
      end else if (r_m_valid && i_m_ready) begin
         r_m_valid <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pkt_done  <= 1'b0;
         r_err_sync  <= 1'b0;
         r_err_len   <= 1'b0;
         r_pkt_count <= '0;
         r_err_count <= '0;
      end else begin
         r_pkt_done <= w_pkt_done_d;
         r_err_sync <= w_err_sync_d;
         r_err_len  <= w_err_len_d;
         if (w_pkt_done_d && (r_pkt_count != '1)) begin
            r_pkt_count <= r_pkt_count + CNT_W'(1);
         end
         if (w_err_len_d && (r_err_count != '1)) begin
            r_err_count <= r_err_count + CNT_W'(1);
         end
      end
   end

   assign o_hdr_timestamp   = r_hdr_ts;
   assign o_hdr_capture_len = r_hdr_len;
   assign o_hdr_error_flags = r_hdr_flags;
   assign o_hdr_valid       = r_hdr_valid;
   assign o_m_ch0           = r_m_ch0;
   assign o_m_ch1           = r_m_ch1;
   assign o_m_valid         = r_m_valid;
   assign o_m_last          = r_m_last;
   assign o_pkt_done        = r_pkt_done;
   assign o_err_sync        = r_err_sync;
   assign o_err_len         = r_err_len;
   assign o_pkt_count       = r_pkt_count;
   assign o_err_count       = r_err_count;

endmodule
